// File: rtl/apb_pkg.sv
// Shared APB definitions: sequencer state encoding and slave geometry.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_AW        = 32;
  localparam int APB_DW        = 8;
  localparam int APB_MEM_DEPTH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Round-robin APB requester arbiter and SETUP/ACCESS sequencer.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ack,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic [AW-1:0]    paddr,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [DW-1:0]    pwdata,
  input  logic [DW-1:0]    prdata,
  input  logic             pready,
  input  logic             pslverr,
  output apb_state_t       state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  apb_state_t      state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_q;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            grant_fire;
  logic            done_fire;
  logic            to_fire;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_write;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // Counts stalled ACCESS cycles; restarts with every new grant.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) to_cnt <= '0;
    else if (grant_fire) to_cnt <= '0;
    else if (state == ACCESS && !pready) to_cnt <= to_cnt + 1'b1;
  end
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    to_fire    = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_fire = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done_fire  = 1'b1;
          state_next = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (to_cnt == CW'(TIMEOUT - 1)) begin
          to_fire    = 1'b1;
          done_fire  = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_write = req_write[i];
      end
    end
  end

  // Pointer moves past the grantee only when its transfer completes.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ptr       <= '0;
      gnt_q     <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (grant_fire) begin
        paddr   <= sel_addr;
        pwrite  <= sel_write;
        pwdata  <= sel_wdata;
        req_ack <= gnt;
        gnt_q   <= gnt_idx;
      end
      if (done_fire) begin
        rsp_valid <= NREQ'(1) << gnt_q;
        rsp_err   <= to_fire | (pready & pslverr);
        rsp_rdata <= (pwrite || to_fire || pslverr) ? '0 : prdata;
        ptr       <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master with a small behavioral APB memory slave.
module tb_apb_arb_master;
  import apb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 8;

  logic             pclk;
  logic             presetn;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]  req_ack;
  logic [NREQ-1:0]  rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    paddr;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic [DW-1:0]    prdata;
  logic             pready;
  logic             pslverr;
  apb_state_t       state;

  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] wdata_a[NREQ];

  bit [DW-1:0] mem[APB_MEM_DEPTH];
  int          wait_states;
  int          acc_cnt;

  int n_checks;
  int n_fail;

  logic [2:0]    exp_q[$];
  logic [2:0]    got_q[$];
  logic [DW-1:0] rd_a[NREQ];
  logic          er_a[NREQ];
  int            ack_cyc[NREQ];
  int            rsp_cyc[NREQ];

  assign req_addr  = {addr_a[1], addr_a[0]};
  assign req_wdata = {wdata_a[1], wdata_a[0]};

  apb_arb_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .state     (state)
  );

  // Clock and reset block
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Behavioral slave: 16-byte memory, error above depth, programmable wait states.
  always_comb begin
    pready  = penable && (acc_cnt >= wait_states);
    pslverr = psel && penable && (paddr >= AW'(APB_MEM_DEPTH));
    prdata  = (paddr < AW'(APB_MEM_DEPTH)) ? mem[paddr[3:0]] : '0;
  end

  always @(posedge pclk) begin
    if (!penable) acc_cnt <= 0;
    else if (!pready) acc_cnt <= acc_cnt + 1;
    if (psel && penable && pready && pwrite && !pslverr) mem[paddr[3:0]] <= pwdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: raise requester i at batch cycle dly[i]; drop it on its ack.
  task automatic run_batch(input logic [1:0] mask, input int d0, input int d1);
    int  dly[NREQ];
    bit  acked[NREQ];
    bit  done[NREQ];
    int  cyc;
    dly[0] = d0;
    dly[1] = d1;
    for (int i = 0; i < NREQ; i++) begin
      acked[i] = 0;
      done[i]  = 0;
    end
    got_q.delete();
    cyc = 0;
    while (cyc < 300 && !((done[0] || !mask[0]) && (done[1] || !mask[1]))) begin
      for (int i = 0; i < NREQ; i++)
        if (mask[i] && !acked[i] && cyc == dly[i]) req_valid[i] = 1'b1;
      @(negedge pclk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i]) begin
          got_q.push_back(3'(i));
          acked[i]     = 1;
          ack_cyc[i]   = cyc;
          req_valid[i] = 1'b0;
        end
        if (rsp_valid[i]) begin
          done[i]    = 1;
          rsp_cyc[i] = cyc;
          rd_a[i]    = rsp_rdata;
          er_a[i]    = rsp_err;
        end
      end
    end
    if (cyc >= 300) check("batch_budget", 64'(cyc), 64'(0));
  endtask

  task automatic check_order(input string tag);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (got_q.size() > 0) check(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
      else check(tag, 64'(7), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = wr;
    addr_a[i]    = a;
    wdata_a[i]   = d;
  endtask

  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    wait_states = 0;
    req_valid   = '0;
    req_write   = '0;
    addr_a[0]   = '0;
    addr_a[1]   = '0;
    wdata_a[0]  = '0;
    wdata_a[1]  = '0;
    presetn     = 1'b0;
    repeat (3) @(negedge pclk);

    check("rst_psel",      64'(psel), 64'(0));
    check("rst_penable",   64'(penable), 64'(0));
    check("rst_paddr",     64'(paddr), 64'(0));
    check("rst_pwdata",    64'(pwdata), 64'(0));
    check("rst_req_ack",   64'(req_ack), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_state",     64'(state), 64'(IDLE));
    presetn = 1'b1;
    @(negedge pclk);

    // Simultaneous reads after reset: 0 then 1, twice
    set_req(0, 1'b0, 32'd7, 8'h00);
    set_req(1, 1'b0, 32'd8, 8'h00);
    run_batch(2'b11, 0, 0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    check_order("order_both_a");
    run_batch(2'b11, 0, 0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    check_order("order_both_b");
    // req1 alone, req0 joins while busy: 1 then 0
    run_batch(2'b11, 1, 0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    check_order("order_1_then_0");
    check("both_rd_err", 64'(er_a[0]), 64'(0));

    // Cycle-exact zero-wait write from requester 0 (pointer now 1, only req0 pending)
    set_req(0, 1'b1, 32'd3, 8'hA5);
    req_valid[0] = 1'b1;
    @(negedge pclk);
    check("wr_ack_c1",   64'(req_ack), 64'(2'b01));
    check("wr_psel_c1",  64'(psel), 64'(1));
    check("wr_pen_c1",   64'(penable), 64'(0));
    check("wr_paddr",    64'(paddr), 64'(3));
    check("wr_pwrite",   64'(pwrite), 64'(1));
    check("wr_pwdata",   64'(pwdata), 64'(8'hA5));
    req_valid[0] = 1'b0;
    @(negedge pclk);
    check("wr_pen_c2",   64'(penable), 64'(1));
    check("wr_ack_c2",   64'(req_ack), 64'(0));
    @(negedge pclk);
    check("wr_rsp_c3",   64'(rsp_valid), 64'(2'b01));
    check("wr_err_c3",   64'(rsp_err), 64'(0));
    check("wr_psel_c3",  64'(psel), 64'(0));

    set_req(0, 1'b0, 32'd3, 8'h00);
    run_batch(2'b01, 0, 0);
    check("rd_back_data", 64'(rd_a[0]), 64'(8'hA5));
    check("rd_back_lat",  64'(rsp_cyc[0] - ack_cyc[0]), 64'(2));

    // req1 alone leaves pointer at 0; error read from req0 then moves it to 1
    run_batch(2'b10, 0, 0);
    set_req(0, 1'b0, 32'd20, 8'h00);
    run_batch(2'b01, 0, 0);
    check("err_rsp_err",   64'(er_a[0]), 64'(1));
    check("err_rsp_rdata", 64'(rd_a[0]), 64'(0));
    set_req(0, 1'b0, 32'd3, 8'h00);
    run_batch(2'b11, 0, 0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    check_order("order_after_err");
    check("err_next_rdata", 64'(rd_a[0]), 64'(8'hA5));

    // Three wait states: APB outputs frozen through ACCESS
    wait_states = 3;
    set_req(0, 1'b1, 32'd5, 8'h3C);
    req_valid[0] = 1'b1;
    @(negedge pclk);
    check("ws_ack", 64'(req_ack), 64'(2'b01));
    req_valid[0] = 1'b0;
    hold_addr  = 32'd5;
    hold_wdata = 8'h3C;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      check("ws_paddr",   64'(paddr), 64'(hold_addr));
      check("ws_pwdata",  64'(pwdata), 64'(hold_wdata));
      check("ws_pwrite",  64'(pwrite), 64'(1));
      check("ws_psel",    64'(psel), 64'(1));
      check("ws_penable", 64'(penable), 64'(1));
      check("ws_no_rsp",  64'(rsp_valid), 64'(0));
    end
    @(negedge pclk);
    check("ws_rsp", 64'(rsp_valid), 64'(2'b01));
    wait_states = 0;
    set_req(0, 1'b0, 32'd5, 8'h00);
    run_batch(2'b01, 0, 0);
    check("ws_rd_back", 64'(rd_a[0]), 64'(8'h3C));

    // Long stall: aborted after 16 ACCESS cycles with the timeout, otherwise waited out
    set_req(0, 1'b0, 32'd3, 8'h00);
    set_req(1, 1'b0, 32'd5, 8'h00);
`ifdef APB_ARB_TIMEOUT_EN
    wait_states = 1000;
    run_batch(2'b11, 0, 2);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    check_order("to_order");
    check("to_access_cycles", 64'(rsp_cyc[0] - ack_cyc[0] - 1), 64'(16));
    check("to_err",   64'(er_a[0]), 64'(1));
    check("to_rdata", 64'(rd_a[0]), 64'(0));
    check("to_err1",  64'(er_a[1]), 64'(1));
`else
    wait_states = 20;
    run_batch(2'b11, 0, 2);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    check_order("stall_order");
    check("stall_access_cycles", 64'(rsp_cyc[0] - ack_cyc[0] - 1), 64'(21));
    check("stall_err",   64'(er_a[0]), 64'(0));
    check("stall_rdata", 64'(rd_a[0]), 64'(8'hA5));
`endif
    wait_states = 5;

    // Reset during ACCESS: outputs drop at once, no response, pointer back to 0
    set_req(0, 1'b0, 32'd3, 8'h00);
    req_valid[0] = 1'b1;
    @(negedge pclk);
    req_valid[0] = 1'b0;
    @(negedge pclk);
    check("rst_mid_pen_before", 64'(penable), 64'(1));
    #2 presetn = 1'b0;
    #1;
    check("rst_mid_psel", 64'(psel), 64'(0));
    check("rst_mid_pen",  64'(penable), 64'(0));
    check("rst_mid_rsp",  64'(rsp_valid), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      check("rst_mid_no_rsp", 64'(rsp_valid), 64'(0));
    end
    presetn = 1'b1;
    wait_states = 0;
    @(negedge pclk);
    check("rst_mid_no_rsp_after", 64'(rsp_valid), 64'(0));
    run_batch(2'b11, 0, 0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    check_order("order_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
# apb_arb_master

Two-port (parameterizable N-port) APB requester arbiter and master sequencer for the `apb_s` memory slave. Local requesters issue single read/write commands. The block grants them in round-robin order and drives the APB SETUP/ACCESS phases onto the shared slave bus. It then returns read data and the slave error to the granted requester. It sits between the test/processor-side requesters and the one APB slave port.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `AW`, 32: address width, matches slave `paddr`.
- `DW`, 8: data width, matches slave `pwdata`/`prdata`.
- `TIMEOUT`, 16: ACCESS-phase cycles without `pready` before abort (used only with the macro).

Ports:
- `pclk` in 1: the single clock; all logic on its rising edge.
- `presetn` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: requester i has a command pending; held until `req_ack[i]`.
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ*AW: packed addresses; slice i = `[i*AW +: AW]`.
- `req_wdata` in NREQ*DW: packed write data.
- `req_ack` out NREQ: one-cycle pulse; the command is latched and the requester may drop or change it.
- `rsp_valid` out NREQ: one-cycle completion pulse for the granted requester.
- `rsp_rdata` out DW: read data, valid with `rsp_valid`; 0 for writes.
- `rsp_err` out 1: slave error or timeout, valid with `rsp_valid`.
- `paddr` out AW: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `pwdata` out DW: APB write data.
- `prdata` in DW: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB slave error.

## Operation
- Reset values:
  - All outputs 0, including `paddr` and `pwdata`.
  - State IDLE, round-robin pointer 0, timeout counter 0.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- **IDLE**
  - `psel`=0, `penable`=0.
  - If any `req_valid` is set: grant the first set bit searching upward from the pointer, wrapping modulo NREQ.
  - Register the grantee's addr/write/wdata into `paddr`/`pwrite`/`pwdata`.
  - Pulse `req_ack[g]` and store `g`. Go to SETUP.
- **SETUP**
  - `psel`=1, `penable`=0.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - On `pready`=1:
    - Register `rsp_valid[g]`=1.
    - `rsp_rdata` = `pwrite` ? 0 : `prdata`.
    - `rsp_err` = `pslverr`.
  - When the error path fires, `rsp_rdata` is forced to 0.
  - Pointer becomes (g+1) mod NREQ. Go to IDLE.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the last ACCESS cycle. In IDLE they hold their last value.
- Addresses pass through unmodified. Range checking (0..15) belongs to the slave, which reports it via `pslverr`.
- A request raised while the bus is busy waits. It is considered at the next IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle; the others keep `req_valid` asserted.
- The pointer advances only on completion, never on grant alone.
- `rsp_valid` and `rsp_err` are single-cycle pulses. `rsp_rdata` holds until the next completion.

## Timing
- Handshake latency:
  - IDLE grant in cycle 0 (`req_ack` visible in cycle 1).
  - SETUP in cycle 1, ACCESS from cycle 2.
  - With zero wait states, `pready` is sampled at the end of cycle 2 and `rsp_valid` is high in cycle 3.
- Minimum transfer period is 3 cycles (IDLE, SETUP, ACCESS). The next grant occurs in the IDLE cycle that coincides with `rsp_valid`.
- Each wait state (`pready`=0 in ACCESS) adds one cycle. All APB outputs are held.
- Reset asserted mid-transfer:
  - `psel`, `penable` and all `rsp_*`/`req_ack` drop asynchronously.
  - The in-flight command is discarded with no response.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter runs in ACCESS and clears on entry to SETUP.
  - When it reaches `TIMEOUT` with `pready` still 0, the block completes with `rsp_valid[g]`=1, `rsp_err`=1, `rsp_rdata`=0.
  - It then drops `psel`/`penable`, advances the pointer and returns to IDLE.
- Undefined: no counter; ACCESS waits for `pready` indefinitely.

## Structure
- Shared package `apb_pkg`:
  - state enum `apb_state_t` {IDLE, SETUP, ACCESS}.
  - `APB_AW`=32, `APB_DW`=8, `APB_MEM_DEPTH`=16.
- Sub-module `rr_arbiter`:
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `gnt` and index `gnt_idx`.
  - Combinational priority rotate. The pointer register lives in the parent.

## Test plan
1. Requester 0 writes addr 3, data 0xA5 (zero wait):
   - `psel` in cycle 1, `penable` in cycle 2.
   - `rsp_valid[0]` in cycle 3 with `rsp_err`=0.
   - A following read of addr 3 returns `rsp_rdata`=0xA5.
2. Both requesters assert reads together after reset:
   - Grant order is 0 then 1.
   - Re-asserting both gives 0 then 1 again. Then only req1 followed by both gives 1, 0.
3. Read of addr 20:
   - Slave returns `pslverr`=1.
   - `rsp_err`=1, `rsp_rdata`=0x00, pointer advances.
4. Slave holds `pready`=0 for 3 ACCESS cycles:
   - `paddr`, `pwdata`, `pwrite`, `psel` and `penable` are unchanged throughout.
   - `rsp_valid` appears 1 cycle after `pready`.
5. With `APB_ARB_TIMEOUT_EN` and `TIMEOUT`=16, `pready` tied 0:
   - `rsp_valid` with `rsp_err`=1 after 16 ACCESS cycles.
   - A pending req1 is granted next.
6. `presetn` pulled low during ACCESS:
   - `psel`/`penable` go 0 immediately, no `rsp_valid`.
   - After release, a simultaneous req0/req1 grants req0 (pointer reset to 0).
